// File: rtl/qstack_pkg.sv
// Shared types and entry packing for the 8-queen position stack.
package qstack_pkg;

   localparam int DATA_W = 6;
   localparam int ROW_W  = 3;
   localparam int COL_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ      = 2'd2,
      ST_READ_WAIT = 2'd3
   } qstack_state_t;

   function automatic logic [DATA_W-1:0] pack_entry(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/queen_stack_ctrl_stack_pointer.sv
// Saturating up/down stack pointer; count is the next free slot.
module stack_pointer #(
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              inc,
   input  logic              dec,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full
);

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] MAX = (ADDR_W+1)'(DEPTH);

   assign empty = (count == '0);
   assign full  = (count == MAX);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && !full) begin
         count <= count + ONE;
      end else if (dec && !empty) begin
         count <= count - ONE;
      end
   end

endmodule

// File: rtl/queen_stack_ctrl.sv
// Sequences push/pop pulses into single-port RAM accesses for the queen stack.
// Optional peek port enabled by defining QSTACK_PEEK_EN.
module queen_stack_ctrl #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DATA_W = qstack_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
`ifdef QSTACK_PEEK_EN
   input  logic              peek,
`endif
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              stack_ready,
   output logic              underflow,
   output logic              overflow,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   occupancy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   import qstack_pkg::*;

   qstack_state_t     state, next_state;
   logic [DATA_W-1:0] wreg;
   logic [ADDR_W-1:0] top_addr;
   logic              start_write, start_read, ovf_req, udf_req, sp_inc, sp_dec;
`ifdef QSTACK_PEEK_EN
   logic              read_is_peek, peek_op;
`endif

   stack_pointer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_sp (
      .clk   (clk),
      .clear (reset),
      .inc   (sp_inc),
      .dec   (sp_dec),
      .count (occupancy),
      .empty (empty),
      .full  (full)
   );

   assign top_addr    = occupancy[ADDR_W-1:0] - ADDR_W'(1);
   assign stack_ready = (state == ST_IDLE);
   assign mem_wdata   = wreg;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state  = state;
      start_write = 1'b0;
      start_read  = 1'b0;
      ovf_req     = 1'b0;
      udf_req     = 1'b0;
      sp_inc      = 1'b0;
      sp_dec      = 1'b0;
`ifdef QSTACK_PEEK_EN
      read_is_peek = 1'b0;
`endif
      unique case (state)
         ST_IDLE: begin
            if (push) begin
               if (full) ovf_req = 1'b1;
               else begin
                  start_write = 1'b1;
                  next_state  = ST_WRITE;
               end
            end else if (pop) begin
               if (empty) udf_req = 1'b1;
               else begin
                  start_read = 1'b1;
                  next_state = ST_READ;
               end
`ifdef QSTACK_PEEK_EN
            end else if (peek) begin
               if (empty) udf_req = 1'b1;
               else begin
                  start_read   = 1'b1;
                  read_is_peek = 1'b1;
                  next_state   = ST_READ;
               end
`endif
            end
         end
         ST_WRITE: begin
            sp_inc     = 1'b1;
            next_state = ST_IDLE;
         end
         ST_READ: begin
`ifdef QSTACK_PEEK_EN
            sp_dec = !peek_op;
`else
            sp_dec = 1'b1;
`endif
            next_state = ST_READ_WAIT;
         end
         ST_READ_WAIT: next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase
   end

   // RAM controls are registered on acceptance so they are stable for the whole access cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wreg      <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         dout      <= '0;
         underflow <= 1'b0;
         overflow  <= 1'b0;
`ifdef QSTACK_PEEK_EN
         peek_op   <= 1'b0;
`endif
      end else begin
         mem_we    <= start_write;
         overflow  <= ovf_req;
         underflow <= udf_req;
         if (start_write) begin
            wreg     <= din;
            mem_addr <= occupancy[ADDR_W-1:0];
         end
         if (start_read) begin
            mem_addr <= top_addr;
`ifdef QSTACK_PEEK_EN
            peek_op  <= read_is_peek;
`endif
         end
         if (state == ST_READ_WAIT) dout <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_queen_stack_ctrl.sv
// Self-checking bench for queen_stack_ctrl: directed vector table, hand sequences, randomized model check.
module tb_queen_stack_ctrl;
   import qstack_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
`ifdef QSTACK_PEEK_EN
   logic       peek = 1'b0;
`endif
   logic [5:0] din = '0;
   logic [5:0] dout;
   logic       stack_ready, underflow, overflow, empty, full;
   logic [3:0] occupancy;
   logic [2:0] mem_addr;
   logic       mem_we;
   logic [5:0] mem_wdata;
   logic [5:0] mem_rdata;
   logic [5:0] ram [8];

   int total = 0;
   int bad = 0;

   queen_stack_ctrl #(.DEPTH(8), .ADDR_W(3), .DATA_W(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .pop         (pop),
`ifdef QSTACK_PEEK_EN
      .peek        (peek),
`endif
      .din         (din),
      .dout        (dout),
      .stack_ready (stack_ready),
      .underflow   (underflow),
      .overflow    (overflow),
      .empty       (empty),
      .full        (full),
      .occupancy   (occupancy),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit         p;
      bit         q;
      logic [5:0] d;
      int         occ;
      logic [5:0] dout;
      bit         ovf;
      bit         udf;
      bit         wr;
      bit         rd;
      int         addr;
   } vec_t;

   vec_t tbl[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_noise();
      push = 1'($urandom_range(0, 1));
      pop  = 1'($urandom_range(0, 1));
      din  = 6'($urandom_range(0, 63));
   endtask

   task automatic check_steady(input int e_occ, input logic [5:0] e_dout);
      chk("occupancy", occupancy, e_occ);
      chk("dout", dout, e_dout);
      chk("empty", empty, int'(e_occ == 0));
      chk("full", full, int'(e_occ == 8));
   endtask

   // One request from IDLE; all timing expectations are fixed latencies.
   task automatic xact(input bit p, input bit q, input logic [5:0] d, input int e_occ,
                       input logic [5:0] e_dout, input bit e_ovf, input bit e_udf,
                       input bit e_wr, input bit e_rd, input int e_addr, input bit noisy);
      chk("ready_before", stack_ready, 1);
      push = p; pop = q; din = d;
      tick();
      push = 1'b0; pop = 1'b0; din = '0;
      chk("overflow", overflow, e_ovf);
      chk("underflow", underflow, e_udf);
      chk("busy", stack_ready, int'(!(e_wr || e_rd)));
      chk("mem_we", mem_we, e_wr);
      if (e_wr) begin
         chk("wr_addr", mem_addr, e_addr);
         chk("wr_data", mem_wdata, d);
      end
      if (e_rd) chk("rd_addr", mem_addr, e_addr);
      if (e_wr || e_rd) begin
         if (noisy) drive_noise();
         tick();
         if (e_rd) begin
            chk("read_wait_busy", stack_ready, 0);
            chk("we_in_read", mem_we, 0);
            if (noisy) drive_noise();
            tick();
         end
         push = 1'b0; pop = 1'b0; din = '0;
      end else begin
         tick();
      end
      chk("pulse_end", int'(overflow | underflow), 0);
      chk("ready_after", stack_ready, 1);
      chk("mem_we_idle", mem_we, 0);
      check_steady(e_occ, e_dout);
   endtask

   initial begin
      logic [5:0] model[$];
      logic [5:0] m_dout;
      int bias;

      // Directed vectors: {push, pop, din, occ, dout, ovf, udf, wr, rd, addr}
      tbl.push_back('{1, 0, 6'o23, 1, 6'o00, 0, 0, 1, 0, 0});
      tbl.push_back('{0, 1, 6'o00, 0, 6'o23, 0, 0, 0, 1, 0});
      tbl.push_back('{0, 1, 6'o00, 0, 6'o23, 0, 1, 0, 0, 0});
      for (int i = 0; i < 8; i++)
         tbl.push_back('{1, 0, 6'(i), i + 1, 6'o23, 0, 0, 1, 0, i});
      tbl.push_back('{1, 0, 6'o55, 8, 6'o23, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 6'o56, 8, 6'o23, 1, 0, 0, 0, 0});
      for (int i = 7; i >= 0; i--)
         tbl.push_back('{0, 1, 6'o00, i, 6'(i), 0, 0, 0, 1, i});
      tbl.push_back('{0, 1, 6'o00, 0, 6'o00, 0, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 6'o11, 1, 6'o00, 0, 0, 1, 0, 0});
      tbl.push_back('{1, 0, 6'o12, 2, 6'o00, 0, 0, 1, 0, 1});
      tbl.push_back('{1, 1, 6'o13, 3, 6'o00, 0, 0, 1, 0, 2});
      tbl.push_back('{0, 1, 6'o00, 2, 6'o13, 0, 0, 0, 1, 2});
      tbl.push_back('{1, 0, 6'o15, 3, 6'o13, 0, 0, 1, 0, 2});

      tick();
      tick();
      reset = 1'b0;
      chk("rst_ready", stack_ready, 1);
      chk("rst_uflow", underflow, 0);
      chk("rst_oflow", overflow, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      check_steady(0, 6'o00);

      foreach (tbl[i])
         xact(tbl[i].p, tbl[i].q, tbl[i].d, tbl[i].occ, tbl[i].dout, tbl[i].ovf,
              tbl[i].udf, tbl[i].wr, tbl[i].rd, tbl[i].addr, 1'b0);

      // Pop pulse arriving during WRITE must be dropped.
      push = 1'b1; din = 6'o14;
      tick();
      push = 1'b0; pop = 1'b1;
      chk("seqw_we", mem_we, 1);
      chk("seqw_addr", mem_addr, 3);
      tick();
      pop = 1'b0;
      chk("seqw_ready", stack_ready, 1);
      chk("seqw_occ", occupancy, 4);
      tick();
      chk("seqw_no_read", stack_ready, 1);
      chk("seqw_occ2", occupancy, 4);

      // Reset during READ_WAIT abandons the pop.
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("seqr_read", stack_ready, 0);
      chk("seqr_addr", mem_addr, 3);
      tick();
      chk("seqr_wait", stack_ready, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("seqr_ready", stack_ready, 1);
      chk("seqr_we", mem_we, 0);
      check_steady(0, 6'o00);

`ifdef QSTACK_PEEK_EN
      xact(1'b1, 1'b0, 6'o31, 1, 6'o00, 0, 0, 1, 0, 0, 1'b0);
      xact(1'b1, 1'b0, 6'o32, 2, 6'o00, 0, 0, 1, 0, 1, 1'b0);
      peek = 1'b1;
      tick();
      peek = 1'b0;
      chk("peek_busy", stack_ready, 0);
      chk("peek_addr", mem_addr, 1);
      tick();
      chk("peek_wait", stack_ready, 0);
      tick();
      chk("peek_ready", stack_ready, 1);
      check_steady(2, 6'o32);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      peek = 1'b1;
      tick();
      peek = 1'b0;
      chk("peek_empty_udf", underflow, 1);
      chk("peek_empty_ready", stack_ready, 1);
      tick();
`endif

      // Randomized phase against a queue-based model.
      model.delete();
      m_dout = '0;
      for (int n = 0; n < 300; n++) begin
         bit p, q, e_ovf, e_udf, e_wr, e_rd;
         logic [5:0] d;
         int addr;
         bias = ((n / 40) % 2 == 0) ? 70 : 25;
         p = ($urandom_range(0, 99) < bias);
         q = 1'($urandom_range(0, 1));
         d = pack_entry(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         e_ovf = 0; e_udf = 0; e_wr = 0; e_rd = 0; addr = 0;
         if (p) begin
            if (model.size() == 8) e_ovf = 1;
            else begin
               e_wr = 1;
               addr = model.size();
               model.push_back(d);
            end
         end else if (q) begin
            if (model.size() == 0) e_udf = 1;
            else begin
               e_rd = 1;
               addr = model.size() - 1;
               m_dout = model.pop_back();
            end
         end
         xact(p, q, d, model.size(), m_dout, e_ovf, e_udf, e_wr, e_rd, addr, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/queen_stack_ctrl.md
Name: queen_stack_ctrl

Overview:
- Sequences the single-port synchronous RAM that holds placed-queen positions for the 8-queen solver.
- Converts one-cycle push/pop pulses from the solver controller into multi-cycle RAM accesses.
- Reports completion through stack_ready and flags underflow/overflow.
- Sits between the solver controller and the position RAM; owns the stack pointer.

Parameters:
- DEPTH, 8, maximum number of stacked entries (one per board row).
- ADDR_W, 3, RAM address width; DEPTH must equal 2**ADDR_W.
- DATA_W, 6, entry width, {row[5:3], col[2:0]}.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears the pointer, FSM and outputs.
- push  in  1  one-cycle request to push din.
- pop  in  1  one-cycle request to pop the top entry into dout.
- din  in  DATA_W  data to push; sampled only in the cycle push is accepted.
- dout  out  DATA_W  registered value of the last popped entry.
- stack_ready  out  1  high only in IDLE.
- underflow  out  1  one-cycle pulse when a pop is requested while empty.
- overflow  out  1  one-cycle pulse when a push is requested while full.
- empty  out  1  sp == 0.
- full  out  1  sp == DEPTH.
- occupancy  out  ADDR_W+1  current sp.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after the address is presented.

Behaviour:
- Reset values: state=IDLE, sp=0, dout=0, underflow=0, overflow=0, mem_we=0, mem_addr=0, mem_wdata=0. After reset, stack_ready=1, empty=1, full=0.
- Stack pointer: sp has ADDR_W+1 bits and points to the next free slot. The top entry is at sp-1.
- FSM states: IDLE, WRITE, READ, READ_WAIT.
- IDLE:
  - stack_ready=1.
  - push & !full: latch din into wreg, go to WRITE.
  - push & full: overflow=1 for this cycle, stay in IDLE.
  - pop & !push & !empty: go to READ.
  - pop & !push & empty: underflow=1 for this cycle, stay in IDLE. sp and dout are unchanged.
  - push & pop together: push wins and pop is dropped silently. If full, overflow pulses and no operation starts.
- WRITE: mem_addr=sp[ADDR_W-1:0], mem_we=1, mem_wdata=wreg; sp<=sp+1; go to IDLE.
- READ: mem_addr=sp-1; sp<=sp-1; go to READ_WAIT.
- READ_WAIT: dout<=mem_rdata; go to IDLE.
- stack_ready is decoded from state, so it is 0 in the cycle after a request is accepted. A waiting controller therefore never sees a stale ready.
- Latency, with the request sampled at edge T:
  - push: busy T+1, ready again at T+2.
  - pop: busy T+1 and T+2; dout valid and ready=1 at T+3.
- Requests arriving while not in IDLE are ignored (not queued) and cause no error pulse.
- mem_we is high only in WRITE. mem_addr holds its last value in IDLE.
- No wrap-around: sp saturates by rule, because push is refused at full and pop at empty.
- Reset mid-operation: the operation is abandoned. A write in progress is cancelled only if reset coincides with the WRITE-cycle edge; the RAM contents themselves are don't-care after reset.

Optional Feature:
- Macro QSTACK_PEEK_EN.
- Defined: adds input peek (1 bit).
  - In IDLE, with push=0 and pop=0, peek & !empty goes to READ without decrementing sp, then READ_WAIT loads dout.
  - Latency is the same as pop.
  - peek on empty pulses underflow.
  - Priority order: push > pop > peek.
- Undefined: no peek port. The top entry is readable only by popping.

Decomposition:
- Package qstack_pkg holds:
  - the state enum (2 bits);
  - DATA_W, ROW_W=3, COL_W=3;
  - a function to pack {row, col} into an entry.
- One sub-module, stack_pointer: an up/down counter with inc/dec/clear inputs and empty/full flags, instantiated once.

Test Plan:
- Reset, then push din=6'o23 → stack_ready low one cycle; mem_we=1 at addr 0 with data 6'o23; ready returns; occupancy=1.
- Push 8 entries 6'o00..6'o07, then one more push → full=1, overflow pulses one cycle, occupancy stays 8, no mem_we.
- From full, pop 8 times → dout sequence 6'o07..6'o00, each valid 3 cycles after its pop; empty=1 at the end.
- Pop on empty → underflow high exactly one cycle, stack_ready stays 1, dout unchanged.
- push and pop in the same cycle with occupancy=2 → push executed, occupancy=3, no read. A pop pulse during WRITE is ignored.
- Assert reset during READ_WAIT with occupancy=4 → next cycle: state IDLE, occupancy=0, dout=0, stack_ready=1. With QSTACK_PEEK_EN, peek after two pushes returns the second entry and occupancy stays 2.
